// File: rtl/mm2s_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mm2s_cmd_sequencer_if
// Purpose  : AXI-Stream command channel between the MM2S command sequencer
//            and the DataMover command slave.
// Signals  : tdata  [71:0] DataMover command word
//            tvalid        command valid (driven by master)
//            tready        command accepted (driven by slave)
// Revision : 1.0 - initial release
// ============================================================================
interface mm2s_cmd_sequencer_if;
  logic [71:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/mm2s_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm2s_cmd_sequencer
// Purpose  : Splits the region [base_addr, base_addr+cap_size) into
//            PACKET_SIZE-byte DataMover read commands, issues them on an
//            AXI-Stream command port, bounds in-flight commands with
//            status-beat credits and optionally loops over the region.
// Ports    : axilite_clk, axilite_rstb (async, active low)
//            m_axis       command stream (master modport)
//            sts_valid    one pulse per returned status beat
//            read_start   level, rising edge starts a run
//            read_reset   synchronous abort/clear, highest priority
//            loop_en      restart at base after the last chunk
//            base_addr, cap_size  region description
//            busy, done, loop_count, outstanding  status outputs
// Revision : 1.0 - initial release
// ============================================================================
module mm2s_cmd_sequencer #(
  parameter int PACKET_SIZE     = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  wire                  axilite_clk,
  input  wire                  axilite_rstb,
  mm2s_cmd_sequencer_if.master m_axis,
  input  wire                  sts_valid,
  input  wire                  read_start,
  input  wire                  read_reset,
  input  wire                  loop_en,
  input  wire  [31:0]          base_addr,
  input  wire  [31:0]          cap_size,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           loop_count,
  output logic [3:0]           outstanding
);

  localparam logic [31:0] c_pkt = 32'(PACKET_SIZE);
  localparam logic [3:0]  c_max = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_start_q;
  logic        r_start_pend;
  logic [31:0] r_base;
  logic [31:0] r_cap;
  logic [31:0] r_offset;
  logic [3:0]  r_tag;
  logic [71:0] r_tdata;
  logic        r_tvalid;
  logic        r_done;
  logic [7:0]  r_loop_count;
  logic [3:0]  r_outstanding;

  logic        w_start_edge;
  logic        w_accept;
  logic [3:0]  w_out_nx;
  logic        w_credit;
  logic [31:0] w_off_nx;
  logic [3:0]  w_tag_nx;

  // Command word: BTT, INCR type, EOF set, SADDR, TAG.
  function automatic logic [71:0] build_cmd(input logic [31:0] base,
                                            input logic [31:0] cap,
                                            input logic [31:0] off,
                                            input logic [3:0]  tag);
    logic [31:0] rem;
    logic [22:0] btt;
    rem = cap - off;
    btt = (rem < c_pkt) ? rem[22:0] : c_pkt[22:0];
    return {4'h0, tag, base + off, 1'b0, 1'b1, 6'h00, 1'b1, btt};
  endfunction

  assign w_start_edge = read_start & ~r_start_q;
  assign w_accept     = r_tvalid & m_axis.tready;
  assign w_off_nx     = r_offset + {9'd0, r_tdata[22:0]};
  assign w_tag_nx     = r_tag + 4'd1;

  // Accept and status in the same cycle cancel; a status beat at zero is dropped.
  always_comb begin
    w_out_nx = r_outstanding;
    if (w_accept && !sts_valid)
      w_out_nx = r_outstanding + 4'd1;
    else if (!w_accept && sts_valid && (r_outstanding != 4'd0))
      w_out_nx = r_outstanding - 4'd1;
  end

  // Credit is judged on the post-update count so back-to-back issue is possible.
  assign w_credit = (w_out_nx < c_max);

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_start_pend  <= 1'b0;
      r_base        <= 32'd0;
      r_cap         <= 32'd0;
      r_offset      <= 32'd0;
      r_tag         <= 4'd0;
      r_tdata       <= 72'd0;
      r_tvalid      <= 1'b0;
      r_done        <= 1'b0;
      r_loop_count  <= 8'd0;
      r_outstanding <= 4'd0;
    end else if (read_reset) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_start_pend  <= 1'b0;
      r_base        <= 32'd0;
      r_cap         <= 32'd0;
      r_offset      <= 32'd0;
      r_tag         <= 4'd0;
      r_tdata       <= 72'd0;
      r_tvalid      <= 1'b0;
      r_done        <= 1'b0;
      r_loop_count  <= 8'd0;
      r_outstanding <= 4'd0;
    end else begin
      r_start_q     <= read_start;
      // Only edges seen while idle can start a run.
      r_start_pend  <= w_start_edge & (r_state == S_IDLE);
      r_done        <= 1'b0;
      r_outstanding <= w_out_nx;
      case (r_state)
        S_IDLE: begin
          if (r_start_pend && (cap_size != 32'd0)) begin
            r_base   <= base_addr;
            r_cap    <= cap_size;
            r_offset <= 32'd0;
            r_tdata  <= build_cmd(base_addr, cap_size, 32'd0, r_tag);
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_tag <= w_tag_nx;
            if (w_off_nx >= r_cap) begin
              if (loop_en) begin
                r_offset <= 32'd0;
                r_tdata  <= build_cmd(r_base, r_cap, 32'd0, w_tag_nx);
                r_tvalid <= w_credit;
                if (r_loop_count != 8'hFF)
                  r_loop_count <= r_loop_count + 8'd1;
              end else begin
                r_tvalid <= 1'b0;
                r_state  <= S_DRAIN;
              end
            end else begin
              r_offset <= w_off_nx;
              r_tdata  <= build_cmd(r_base, r_cap, w_off_nx, w_tag_nx);
              r_tvalid <= w_credit;
            end
          end else if (!r_tvalid) begin
            // tvalid, once raised, holds with tdata until accepted.
            r_tvalid <= w_credit;
          end
        end
        S_DRAIN: begin
          if (r_outstanding == 4'd0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign loop_count    = r_loop_count;
  assign outstanding   = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_mm2s_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm2s_cmd_sequencer
// Purpose  : Directed self-checking bench for mm2s_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm2s_cmd_sequencer;

  logic        clk;
  logic        rstb;
  logic        sts_man;
  logic        sts_auto;
  logic        sts_valid;
  logic        read_start;
  logic        read_reset;
  logic        loop_en;
  logic [31:0] base_addr;
  logic [31:0] cap_size;
  logic        busy;
  logic        done;
  logic [7:0]  loop_count;
  logic [3:0]  outstanding;
  logic [4:0]  sts_pipe;

  logic [71:0] cmds[$];
  int          n_total;
  int          n_bad;

  mm2s_cmd_sequencer_if intf ();

  mm2s_cmd_sequencer #(.PACKET_SIZE(4096), .MAX_OUTSTANDING(4)) dut (
    .axilite_clk  (clk),
    .axilite_rstb (rstb),
    .m_axis       (intf.master),
    .sts_valid    (sts_valid),
    .read_start   (read_start),
    .read_reset   (read_reset),
    .loop_en      (loop_en),
    .base_addr    (base_addr),
    .cap_size     (cap_size),
    .busy         (busy),
    .done         (done),
    .loop_count   (loop_count),
    .outstanding  (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status beat returned 5 cycles after each accepted command when enabled.
  assign sts_valid = sts_pipe[4] | sts_man;
  always @(posedge clk) begin
    if (!rstb) sts_pipe <= 5'd0;
    else       sts_pipe <= {sts_pipe[3:0], sts_auto & intf.tvalid & intf.tready};
  end

  always @(posedge clk) begin
    if (rstb && !read_reset && intf.tvalid && intf.tready)
      cmds.push_back(intf.tdata);
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_run();
    read_reset = 1'b1;
    tick();
    read_reset = 1'b0;
    tick(8);
    cmds.delete();
  endtask

  task automatic start_run();
    read_start = 1'b1;
    tick();
    read_start = 1'b0;
  endtask

  logic [71:0] held;
  int          cnt;
  logic        flag;

  initial begin
    n_total = 0; n_bad = 0;
    rstb = 1'b0; sts_man = 1'b0; sts_auto = 1'b1; read_start = 1'b0;
    read_reset = 1'b0; loop_en = 1'b0; base_addr = 32'h1000_0000; cap_size = 32'h3000;
    intf.tready = 1'b1;
    tick(3);
    check("rst_tvalid", {71'd0, intf.tvalid}, 72'd0);
    check("rst_tdata", intf.tdata, 72'd0);
    check("rst_busy", {71'd0, busy}, 72'd0);
    check("rst_done", {71'd0, done}, 72'd0);
    check("rst_loopcnt", {64'd0, loop_count}, 72'd0);
    check("rst_outst", {68'd0, outstanding}, 72'd0);
    rstb = 1'b1;
    tick(2);

    // Three full packets, single pass, with latency check.
    start_run();
    check("lat_e0_tvalid", {71'd0, intf.tvalid}, 72'd0);
    tick();
    check("lat_e1_tvalid", {71'd0, intf.tvalid}, 72'd0);
    check("lat_e1_busy", {71'd0, busy}, 72'd1);
    tick();
    check("lat_e2_tvalid", {71'd0, intf.tvalid}, 72'd1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) cnt++;
    end
    check("a_ncmd", 72'(cmds.size()), 72'd3);
    check("a_cmd0", cmds[0], 72'h00_10000000_40801000);
    check("a_cmd1", cmds[1], 72'h01_10001000_40801000);
    check("a_cmd2", cmds[2], 72'h02_10002000_40801000);
    check("a_done_pulses", 72'(cnt), 72'd1);
    check("a_busy_end", {71'd0, busy}, 72'd0);
    check("a_outst_end", {68'd0, outstanding}, 72'd0);
    clear_run();

    // Short last chunk.
    cap_size = 32'h2800;
    start_run();
    tick(60);
    check("b_ncmd", 72'(cmds.size()), 72'd3);
    check("b_last", cmds[2], 72'h02_10002000_40800800);
    clear_run();

    // Zero-length start does nothing.
    cap_size = 32'h0;
    start_run();
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (intf.tvalid || busy || done) flag = 1'b1;
    end
    check("z_no_activity", {71'd0, flag}, 72'd0);
    clear_run();

    // Credit limit with no status returned.
    sts_auto = 1'b0;
    cap_size = 32'h10000;
    start_run();
    tick(20);
    check("c_ncmd4", 72'(cmds.size()), 72'd4);
    check("c_tvalid_lo", {71'd0, intf.tvalid}, 72'd0);
    check("c_outst4", {68'd0, outstanding}, 72'd4);
    sts_man = 1'b1;
    tick();
    sts_man = 1'b0;
    tick(10);
    check("c_ncmd5", 72'(cmds.size()), 72'd5);
    check("c_cmd4_saddr", {40'd0, cmds[4][63:32]}, 72'h1000_4000);
    check("c_outst_again", {68'd0, outstanding}, 72'd4);
    check("c_tvalid_lo2", {71'd0, intf.tvalid}, 72'd0);
    clear_run();

    // Backpressure: tvalid/tdata hold; then read_reset mid-handshake.
    sts_auto = 1'b1;
    intf.tready = 1'b0;
    cap_size = 32'h3000;
    start_run();
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      tick();
      flag = intf.tvalid;
    end
    check("s_tvalid_seen", {71'd0, flag}, 72'd1);
    held = intf.tdata;
    check("s_held_word", held, 72'h00_10000000_40801000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s_tvalid_hold", {71'd0, intf.tvalid}, 72'd1);
      check("s_tdata_hold", intf.tdata, 72'h00_10000000_40801000);
    end
    read_reset = 1'b1;
    tick();
    read_reset = 1'b0;
    check("s_rr_tvalid", {71'd0, intf.tvalid}, 72'd0);
    check("s_rr_busy", {71'd0, busy}, 72'd0);
    check("s_rr_tdata", intf.tdata, 72'd0);
    intf.tready = 1'b1;
    clear_run();

    // Looping with loop_count saturation, then abort.
    loop_en = 1'b1;
    base_addr = 32'h2000_0000;
    cap_size = 32'h2000;
    start_run();
    for (int i = 0; i < 200 && cmds.size() < 4; i++) tick();
    check("l_n4", 72'(cmds.size()), 72'd4);
    check("l_sa0", {40'd0, cmds[0][63:32]}, 72'h2000_0000);
    check("l_sa1", {40'd0, cmds[1][63:32]}, 72'h2000_1000);
    check("l_sa2", {40'd0, cmds[2][63:32]}, 72'h2000_0000);
    check("l_sa3", {40'd0, cmds[3][63:32]}, 72'h2000_1000);
    check("l_cnt2", {64'd0, loop_count}, 72'd2);
    for (int i = 0; i < 5000 && loop_count != 8'hFF; i++) tick();
    check("l_cnt255", {64'd0, loop_count}, 72'd255);
    tick(50);
    check("l_cnt_sat", {64'd0, loop_count}, 72'd255);
    check("l_busy", {71'd0, busy}, 72'd1);
    read_reset = 1'b1;
    tick();
    read_reset = 1'b0;
    check("l_rr_tvalid", {71'd0, intf.tvalid}, 72'd0);
    check("l_rr_cnt", {64'd0, loop_count}, 72'd0);
    check("l_rr_outst", {68'd0, outstanding}, 72'd0);
    tick(10);
    check("l_underflow", {68'd0, outstanding}, 72'd0);
    loop_en = 1'b0;
    clear_run();

    // Address wrap and coincident status/accept.
    sts_auto = 1'b0;
    intf.tready = 1'b0;
    base_addr = 32'hFFFF_F000;
    cap_size = 32'h2000;
    start_run();
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      tick();
      flag = intf.tvalid;
    end
    check("w_tvalid_seen", {71'd0, flag}, 72'd1);
    intf.tready = 1'b1;
    tick();
    intf.tready = 1'b0;
    check("w_outst1", {68'd0, outstanding}, 72'd1);
    intf.tready = 1'b1;
    sts_man = 1'b1;
    tick();
    intf.tready = 1'b0;
    sts_man = 1'b0;
    check("w_coincident", {68'd0, outstanding}, 72'd1);
    check("w_ncmd", 72'(cmds.size()), 72'd2);
    check("w_sa0", {40'd0, cmds[0][63:32]}, 72'hFFFF_F000);
    check("w_sa1", {40'd0, cmds[1][63:32]}, 72'h0000_0000);
    check("w_drain_busy", {71'd0, busy}, 72'd1);
    sts_man = 1'b1;
    tick();
    sts_man = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt++;
    end
    check("w_done", 72'(cnt), 72'd1);
    check("w_idle", {71'd0, busy}, 72'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
